// File: rtl/kgp_risc_pkg.sv
// Shared KGP-RISC decode constants: opcode values, extend-type selects and
// instruction field positions used by the fetch-to-decode boundary.
package kgp_risc_pkg;

   localparam int OPC_W = 6;

   localparam logic [OPC_W-1:0] OPC_RTYPE = 6'b000000;
   localparam logic [OPC_W-1:0] OPC_ALUI  = 6'b000001;
   localparam logic [OPC_W-1:0] OPC_LOAD  = 6'b000010;
   localparam logic [OPC_W-1:0] OPC_STORE = 6'b000011;
   localparam logic [OPC_W-1:0] OPC_BRR   = 6'b000100;
   localparam logic [OPC_W-1:0] OPC_JUMP  = 6'b000101;
   localparam logic [OPC_W-1:0] OPC_HALT  = 6'b000110;

   localparam logic [1:0] EXT_IMM16 = 2'b00;
   localparam logic [1:0] EXT_OFF21 = 2'b01;
   localparam logic [1:0] EXT_TGT26 = 2'b10;
   localparam logic [1:0] EXT_NONE  = 2'b11;

   localparam int OPC_MSB  = 31;
   localparam int OPC_LSB  = 26;
   localparam int RS_MSB   = 25;
   localparam int RS_LSB   = 21;
   localparam int RT_MSB   = 20;
   localparam int RT_LSB   = 16;
   localparam int FUNC_MSB = 4;
   localparam int FUNC_LSB = 0;
   localparam int IMM_MSB  = 25;
   localparam int IMM_LSB  = 0;

endpackage

// File: rtl/opcode_classifier.sv
// Combinational opcode decode: selects the immediate extend type and flags
// opcodes that are not in the decode table.
module opcode_classifier
   import kgp_risc_pkg::*;
(
   input  logic [OPC_W-1:0] i_opcode,
   output logic [1:0]       o_extend_type,
   output logic             o_illegal
);

   always_comb begin
      o_extend_type = EXT_NONE;
      o_illegal     = 1'b0;
      case (i_opcode)
         OPC_RTYPE: o_extend_type = EXT_NONE;
         OPC_ALUI:  o_extend_type = EXT_IMM16;
         OPC_LOAD:  o_extend_type = EXT_IMM16;
         OPC_STORE: o_extend_type = EXT_IMM16;
         OPC_BRR:   o_extend_type = EXT_OFF21;
         OPC_JUMP:  o_extend_type = EXT_TGT26;
         OPC_HALT:  o_extend_type = EXT_NONE;
         default:   o_illegal     = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered fetch-to-decode boundary: main output register plus one skid
// entry, decoding the opcode at capture so the outputs are pure flops.
module instr_decode_stage
   import kgp_risc_pkg::*;
#(
   parameter int PC_W  = 32,
   parameter int OPC_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_instr,
   input  logic [PC_W-1:0]   in_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OPC_W-1:0]  out_opcode,
   output logic [4:0]        out_rs,
   output logic [4:0]        out_rt,
   output logic [4:0]        out_func,
   output logic [25:0]       out_imm_field,
   output logic [1:0]        out_extend_type,
   output logic              out_illegal,
   output logic [PC_W-1:0]   out_pc
);

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both high. Once out_valid is up, it and the output data hold until
   // out_ready (or flush/reset). in_ready is a flop and never follows out_ready
   // combinationally.

   logic              r_main_valid;
   logic [31:0]       r_main_instr;
   logic [PC_W-1:0]   r_main_pc;
   logic [1:0]        r_main_ext;
   logic              r_main_ill;

   logic              r_skid_valid;
   logic [31:0]       r_skid_instr;
   logic [PC_W-1:0]   r_skid_pc;
   logic [1:0]        r_skid_ext;
   logic              r_skid_ill;

   logic              r_in_ready;

   logic [1:0]        w_in_ext;
   logic              w_in_ill;
   logic              w_in_xfer;
   logic              w_main_free;

   opcode_classifier u_classifier (
      .i_opcode      (in_instr[OPC_MSB:OPC_LSB]),
      .o_extend_type (w_in_ext),
      .o_illegal     (w_in_ill)
   );

   // Input taken during flush is discarded, so it never counts as a transfer.
   assign w_in_xfer   = in_valid & r_in_ready & ~flush;
   assign w_main_free = ~r_main_valid | out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_main_valid <= 1'b0;
         r_main_instr <= '0;
         r_main_pc    <= '0;
         r_main_ext   <= EXT_NONE;
         r_main_ill   <= 1'b0;
         r_skid_valid <= 1'b0;
         r_skid_instr <= '0;
         r_skid_pc    <= '0;
         r_skid_ext   <= EXT_NONE;
         r_skid_ill   <= 1'b0;
         r_in_ready   <= 1'b1;
      end else if (flush) begin
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
         r_in_ready   <= 1'b1;
      end else if (w_main_free) begin
         // Skid is older than any input, so it wins; in_ready is low then.
         if (r_skid_valid) begin
            r_main_valid <= 1'b1;
            r_main_instr <= r_skid_instr;
            r_main_pc    <= r_skid_pc;
            r_main_ext   <= r_skid_ext;
            r_main_ill   <= r_skid_ill;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
         end else if (w_in_xfer) begin
            r_main_valid <= 1'b1;
            r_main_instr <= in_instr;
            r_main_pc    <= in_pc;
            r_main_ext   <= w_in_ext;
            r_main_ill   <= w_in_ill;
         end else begin
            r_main_valid <= 1'b0;
         end
      end else if (w_in_xfer) begin
         r_skid_valid <= 1'b1;
         r_skid_instr <= in_instr;
         r_skid_pc    <= in_pc;
         r_skid_ext   <= w_in_ext;
         r_skid_ill   <= w_in_ill;
         r_in_ready   <= 1'b0;
      end
   end

   assign in_ready        = r_in_ready;
   assign out_valid       = r_main_valid;
   assign out_opcode      = r_main_instr[OPC_MSB:OPC_LSB];
   assign out_rs          = r_main_instr[RS_MSB:RS_LSB];
   assign out_rt          = r_main_instr[RT_MSB:RT_LSB];
   assign out_func        = r_main_instr[FUNC_MSB:FUNC_LSB];
   assign out_imm_field   = r_main_instr[IMM_MSB:IMM_LSB];
   assign out_extend_type = r_main_ext;
   assign out_illegal     = r_main_ill;
   assign out_pc          = r_main_pc;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: a 2-deep in-order buffer model checked every
// negative edge, plus directed cases with literal expectations.
module tb_instr_decode_stage;

   localparam int PC_W = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_instr;
   logic [PC_W-1:0]   in_pc;
   logic              out_valid;
   logic              out_ready;
   logic [5:0]        out_opcode;
   logic [4:0]        out_rs;
   logic [4:0]        out_rt;
   logic [4:0]        out_func;
   logic [25:0]       out_imm_field;
   logic [1:0]        out_extend_type;
   logic              out_illegal;
   logic [PC_W-1:0]   out_pc;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: accepted {pc, instr} pairs in issue order; capacity two.
   logic [63:0] exp_q[$];

   instr_decode_stage #(.PC_W(PC_W), .OPC_W(6)) dut (
      .clk             (clk),
      .rst             (rst),
      .flush           (flush),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_instr        (in_instr),
      .in_pc           (in_pc),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_opcode      (out_opcode),
      .out_rs          (out_rs),
      .out_rt          (out_rt),
      .out_func        (out_func),
      .out_imm_field   (out_imm_field),
      .out_extend_type (out_extend_type),
      .out_illegal     (out_illegal),
      .out_pc          (out_pc)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Extend type per opcode from the decode table; opcodes >= 7 are illegal.
   function automatic logic [2:0] exp_decode(input logic [5:0] op);
      logic [1:0] ext_tbl [7];
      ext_tbl = '{2'd3, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
      if (op < 6'd7) return {ext_tbl[op], 1'b0};
      return {2'd3, 1'b1};
   endfunction

   // ---------------- scoreboard / compare process ----------------
   logic        prev_stall = 1'b0;
   logic [95:0] prev_out;

   always @(negedge clk) begin
      logic [63:0] e;
      logic [2:0]  d;
      logic        pop;
      logic        push;
      if (rst) begin
         exp_q.delete();
         prev_stall = 1'b0;
      end else begin
         check("out_valid", out_valid, exp_q.size() > 0);
         check("in_ready", in_ready, exp_q.size() < 2);
         if (exp_q.size() > 0) begin
            e = exp_q[0];
            d = exp_decode(e[31:26]);
            check("out_opcode", out_opcode, e[31:26]);
            check("out_rs", out_rs, e[25:21]);
            check("out_rt", out_rt, e[20:16]);
            check("out_func", out_func, e[4:0]);
            check("out_imm_field", out_imm_field, e[25:0]);
            check("out_pc", out_pc, e[63:32]);
            check("out_extend_type", out_extend_type, d[2:1]);
            check("out_illegal", out_illegal, d[0]);
         end
         if (prev_stall)
            check("stall_stable", {out_valid, out_opcode, out_rs, out_rt, out_func,
                                   out_imm_field, out_extend_type, out_illegal, out_pc}, prev_out);
         prev_stall = out_valid && !out_ready && !flush;
         prev_out   = {out_valid, out_opcode, out_rs, out_rt, out_func,
                       out_imm_field, out_extend_type, out_illegal, out_pc};
         // Advance the model with the inputs that the next rising edge samples.
         if (flush) begin
            exp_q.delete();
         end else begin
            pop  = (exp_q.size() > 0) && out_ready;
            push = in_valid && (exp_q.size() < 2);
            if (pop) void'(exp_q.pop_front());
            if (push) exp_q.push_back({in_pc, in_instr});
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle();
      in_valid = 1'b0;
      flush    = 1'b0;
   endtask

   task automatic send_one(input logic [31:0] instr, input logic [31:0] pc);
      in_valid = 1'b1;
      in_instr = instr;
      in_pc    = pc;
      step();
      in_valid = 1'b0;
   endtask

   task automatic drain(input int cycles);
      idle();
      out_ready = 1'b1;
      repeat (cycles) step();
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_out_valid"}, out_valid, 1'b0);
      check({tag, "_in_ready"}, in_ready, 1'b1);
      check({tag, "_ext"}, out_extend_type, 2'b11);
      check({tag, "_pc"}, out_pc, 32'h0);
      check({tag, "_imm"}, out_imm_field, 26'h0);
      check({tag, "_illegal"}, out_illegal, 1'b0);
   endtask

   // ---------------- directed + random stimulus ----------------
   initial begin
      int cnt;
      int idx;
      logic [31:0] items [3];

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_instr = '0; in_pc = '0;
      #1;
      check_reset_values("reset");
      step(); step();
      rst = 1'b0;
      step();

      // ALU-imm single
      send_one(32'h0400_8001, 32'h10);
      @(negedge clk);
      check("alui_valid", out_valid, 1'b1);
      check("alui_ext", out_extend_type, 2'b00);
      check("alui_imm", out_imm_field, 26'h000_8001);
      check("alui_rs", out_rs, 5'd0);
      check("alui_rt", out_rt, 5'd0);
      check("alui_pc", out_pc, 32'h10);
      drain(2);

      // jump
      send_one(32'h17FF_FFFE, 32'h20);
      @(negedge clk);
      check("jump_opcode", out_opcode, 6'b000101);
      check("jump_ext", out_extend_type, 2'b10);
      check("jump_imm", out_imm_field, 26'h3FF_FFFE);
      drain(2);

      // illegal opcode still delivered
      send_one(32'hFC00_1234, 32'h30);
      @(negedge clk);
      check("illegal_valid", out_valid, 1'b1);
      check("illegal_flag", out_illegal, 1'b1);
      check("illegal_ext", out_extend_type, 2'b11);
      drain(2);

      // back-to-back stream of 8
      cnt = 0; idx = 0;
      for (int i = 0; i < 10; i++) begin
         in_valid = (i < 8);
         in_instr = {6'(i % 7), 26'($urandom)};
         in_pc    = 32'h100 + 32'(4 * i);
         @(negedge clk);
         if (out_valid) cnt++;
         if (!in_ready) idx++;
         step();
      end
      check("stream_valid_cycles", cnt, 8);
      check("stream_ready_drops", idx, 0);
      drain(2);

      // stall with three pending instructions
      items[0] = 32'h0822_0003; items[1] = 32'h0C43_0004; items[2] = 32'h1064_0005;
      out_ready = 1'b0;
      idx = 0;
      for (int i = 0; i < 4; i++) begin
         in_valid = (idx < 3);
         in_instr = items[idx % 3];
         in_pc    = 32'h200 + 32'(idx);
         @(negedge clk);
         if (in_valid && in_ready) idx++;
         step();
      end
      @(negedge clk);
      check("stall_accepted", idx, 2);
      check("stall_in_ready", in_ready, 1'b0);
      step();
      out_ready = 1'b1;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         in_valid = (idx < 3);
         in_instr = items[idx % 3];
         in_pc    = 32'h200 + 32'(idx);
         @(negedge clk);
         if (in_valid && in_ready) idx++;
         if (out_valid && out_ready) cnt++;
         step();
      end
      check("release_accepted", idx, 3);
      check("release_delivered", cnt, 3);
      drain(2);

      // flush with both entries full and a concurrent input
      out_ready = 1'b0;
      send_one(32'h0401_1111, 32'h300);
      send_one(32'h0401_2222, 32'h304);
      @(negedge clk);
      check("preflush_full", in_ready, 1'b0);
      step();
      flush = 1'b1; in_valid = 1'b1; in_instr = 32'h0401_3333; in_pc = 32'h308;
      out_ready = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      check("flush_out_valid", out_valid, 1'b0);
      check("flush_in_ready", in_ready, 1'b1);
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         @(negedge clk);
         if (out_valid) cnt++;
      end
      check("flush_no_ghost", cnt, 0);
      step();

      // async reset mid-stream
      out_ready = 1'b0;
      send_one(32'h0802_5555, 32'h400);
      send_one(32'h0802_6666, 32'h404);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_reset_values("midrst");
      step(); step();
      rst = 1'b0;
      out_ready = 1'b1;
      step();

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         logic [5:0] op;
         op = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(7, 63)) : 6'($urandom_range(0, 6));
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 49) == 0);
         in_instr  = {op, 26'($urandom)};
         in_pc     = $urandom;
         step();
      end
      drain(4);
      @(negedge clk);
      check("final_empty", out_valid, 1'b0);
      check("final_ready", in_ready, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_decode_stage.md
Name: instr_decode_stage

Overview:
- Registered fetch-to-decode boundary of the KGP-RISC core, with a valid/ready handshake.
- Accepts a 32-bit instruction word plus its PC from fetch.
- Classifies the opcode and produces the 26-bit immediate field and 2-bit extend-type select consumed by the sign-extension block.
- Also provides register specifiers and an illegal-opcode flag to the rest of decode.
- A 2-entry skid buffer gives full throughput with a registered ready toward fetch.

Parameters:
- PC_W, 32, width of the program-counter field carried with each instruction.
- OPC_W, 6, opcode width (instr[31:26]); fixed by the ISA; parameter exists for package consistency only.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous pipeline flush (branch taken / redirect).
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept; registered.
- in_instr  in  32  instruction word.
- in_pc  in  PC_W  address of in_instr.
- out_valid  out  1  decoded instruction available.
- out_ready  in  1  downstream accepts.
- out_opcode  out  6  instr[31:26].
- out_rs  out  5  instr[25:21].
- out_rt  out  5  instr[20:16].
- out_func  out  5  instr[4:0]; R-type function.
- out_imm_field  out  26  instr[25:0], raw; the extender selects the slice.
- out_extend_type  out  2  00 = imm16, 01 = off21, 10 = tgt26, 11 = none.
- out_illegal  out  1  opcode not in the decode table.
- out_pc  out  PC_W  PC of the decoded instruction.

Behaviour:
Reset and handshake:
- Reset (async assert, sync-released by the system):
  - out_valid = 0, in_ready = 1, skid empty.
  - All data outputs = 0; out_extend_type = 2'b11.
- Transfer on input when in_valid & in_ready; on output when out_valid & out_ready.
- Latency: an instruction accepted in cycle N appears on the outputs in cycle N+1 if the main register is free.
- Throughput: 1 instruction/cycle while out_ready = 1.

Storage:
- Main register:
  - Loads from the skid entry if the skid is full, else from the input, whenever it is empty or being drained this cycle.
- Skid entry:
  - Captures the input when an input transfer occurs, the main register is full, and it is not draining.
- in_ready = !skid_full, registered; never depends combinationally on out_ready.
- Order is preserved: the skid entry always issues before any newer input.

Decode table (registered with the data, computed at capture):
- 000000 R-type: ext 11.
- 000001 ALU-imm: ext 00.
- 000010 load: ext 00.
- 000011 store: ext 00.
- 000100 reg-relative branch: ext 01.
- 000101 jump / jal: ext 10.
- 000110 halt: ext 11.
- All other opcodes: ext 11, out_illegal = 1, passed downstream (not dropped).

Boundary conditions:
- Both entries full, out_ready = 0: in_ready = 0, outputs held stable bit-for-bit.
- Both full and out_ready = 1: main takes skid, skid empties; in_ready rises next cycle.
- Simultaneous input and output transfer with skid empty: main replaced, no bubble.
- flush = 1:
  - Both entries are invalidated next cycle; out_valid = 0, in_ready = 1.
  - An input handshake in the flush cycle is discarded.
  - An output handshake in the flush cycle still completes (downstream owns it).
- out_valid and output data must never change while out_valid & !out_ready, except by flush or reset.
- rst mid-operation: immediate return to the reset state; in-flight instructions are lost.

Decomposition:
- Package kgp_risc_pkg:
  - Opcode localparams (OPC_RTYPE, OPC_ALUI, OPC_LOAD, OPC_STORE, OPC_BRR, OPC_JUMP, OPC_HALT).
  - Extend-type localparams EXT_IMM16 = 2'b00, EXT_OFF21 = 2'b01, EXT_TGT26 = 2'b10, EXT_NONE = 2'b11.
  - Field-position constants.
- Natural sub-module: opcode_classifier, combinational; maps opcode to {extend_type, illegal}.
- The skid register logic stays inline in the stage.

Test Plan:
- Reset, then a single 32'h0400_8001 (ALU-imm) at pc 0x10, out_ready = 1 -> next cycle out_valid = 1:
  - out_extend_type = 00, out_imm_field = 26'h000_8001, out_rs = 0, out_rt = 0, out_pc = 0x10.
- Jump 32'h17FF_FFFE -> out_opcode = 000101, out_extend_type = 10, out_imm_field = 26'h3FF_FFFE.
- Back-to-back stream of 8 instructions, out_ready = 1 throughout -> 8 consecutive out_valid cycles, in order, in_ready never drops.
- Hold out_ready = 0 for 4 cycles while feeding 3 instructions:
  - in_ready falls after 2 are accepted; outputs are stable.
  - Release -> all 3 emerge in order, none lost or duplicated.
- Opcode 6'b111111 -> out_illegal = 1, out_extend_type = 11, instruction still delivered.
- flush with both entries full and a concurrent in_valid -> next cycle out_valid = 0, in_ready = 1, the flushed and concurrent instructions never appear.
- Assert rst mid-stream -> outputs reach reset values immediately, without waiting for a clock edge.
